serial_mod_sub: RTL and testbench
=================================

Name: serial_mod_sub

Overview:
- Bit-serial modular subtractor for the NTT butterfly datapath: computes D = (A − B) mod MODULUS, LSB first, one bit per clock.
- Uses a single 1-bit full-adder slice (two half adders plus OR) and a carry flip-flop.
- It is the subtract-direction companion of the adder slice.
- Subtract pass forms A + ~B + 1. If that pass produces a borrow, an optional correction pass adds MODULUS.
- Sits between the coefficient buffer and the butterfly output register, behind valid/ready handshakes on both sides.

Parameters:
WIDTH, 12, operand and result width in bits
MODULUS, 3329, prime modulus; must satisfy 1 < MODULUS < 2^WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset; only reset in the block
in_valid  input  1  operands a, b valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  minuend, requirement a < MODULUS
b  input  WIDTH  subtrahend, requirement b < MODULUS
out_valid  output  1  d holds a final result
out_ready  input  1  consumer accepts d
d  output  WIDTH  result (a − b) mod MODULUS
busy  output  1  high in SUB or CORR

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, d = 0. Shift registers, bit counter and carry flip-flop all clear to 0.
- Datapath: one 1-bit full adder with inputs x = shA[0], y = op[0], cin = carry_q.
  - Sum bit shifts into the MSB of the result register (right shift). After WIDTH shifts, the LSB is at bit 0.
  - Carry-out is registered into carry_q.
  - shA shifts right each active cycle.
- Counter: log2(WIDTH)+1 bits; counts 0..WIDTH−1 and is cleared on every state entry.
- IDLE state:
  - in_ready = 1.
  - On in_valid && in_ready: load shA ← a and shB ← ~b; set carry_q ← 1; go to SUB.
- SUB state (WIDTH cycles):
  - op = shB[0]; shB shifts right each cycle.
  - On count WIDTH−1, the final carry is examined. carry = 1 means no borrow: go to DONE.
  - carry = 0 means borrow: reload shA ← result register, load shB ← MODULUS, set carry_q ← 0, go to CORR.
- CORR state (WIDTH cycles):
  - Adds MODULUS to the wrapped difference.
  - Final carry-out is discarded: the sum wraps mod 2^WIDTH and equals a − b + MODULUS.
  - After count WIDTH−1, go to DONE.
- DONE state:
  - out_valid = 1 and d = result register.
  - d is held stable while out_ready = 0.
  - On out_ready: go to IDLE; out_valid drops the following cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: accept at cycle t.
  - No borrow (a ≥ b): out_valid first high at t+WIDTH+1.
  - Borrow (a < b): out_valid first high at t+2·WIDTH+1.
- in_valid is ignored outside IDLE. a and b are sampled only at accept.
- Out-of-range inputs (a or b ≥ MODULUS):
  - No error flag is raised.
  - Result is the 2^WIDTH-wrapped difference with at most one MODULUS correction.
  - Result is deterministic but unspecified as a residue.
- Reset asserted mid-SUB/CORR/DONE: the operation is abandoned with no partial output. Outputs return to reset values immediately.
- busy = (state == SUB) || (state == CORR).

Test Plan (WIDTH=12, MODULUS=3329):
- a=100, b=30, out_ready=1 → d=70, out_valid at accept+13, never enters CORR.
- a=30, b=100 → borrow path, d=3259, out_valid at accept+25, busy high 24 cycles.
- a=3328, b=3328 → d=0 with no CORR; then a=0, b=3328 → d=1 via CORR.
- Backpressure: a=5, b=9, out_ready held low 6 cycles after out_valid → d=3325 stable. in_ready=0 and in_valid ignored throughout; accept resumes the cycle after IDLE re-entry.
- Reset mid-operation: a=30, b=100, drop rst_n during CORR count 4 → out_valid=0, d=0, in_ready=1 immediately. Next a=7, b=7 → d=0 at accept+13.
- Back-to-back: 200 random in-range pairs with random out_ready → every d equals (a−b) mod 3329 in order, and no result is lost or duplicated.

Source files
------------

// File: rtl/serial_mod_sub.sv
// Bit-serial modular subtractor: d = (a - b) mod MODULUS, LSB first, one bit per clock.
// A subtract pass forms a + ~b + 1; a borrow triggers one correction pass adding MODULUS.
module serial_mod_sub #(
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned MODULUS = 3329
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOD_W    = WIDTH'(MODULUS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SUB  = 2'd1,
      S_CORR = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sha_q, sha_d;
   logic [WIDTH-1:0]   shb_q, shb_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic               fa_x, fa_y, fa_h1, fa_c1, fa_c2, fa_sum, fa_cout;
   logic [WIDTH-1:0]   res_shift;

   // Single full-adder slice built from two half adders and an OR
   assign fa_x      = sha_q[0];
   assign fa_y      = shb_q[0];
   assign fa_h1     = fa_x ^ fa_y;
   assign fa_c1     = fa_x & fa_y;
   assign fa_sum    = fa_h1 ^ carry_q;
   assign fa_c2     = fa_h1 & carry_q;
   assign fa_cout   = fa_c1 | fa_c2;
   assign res_shift = {fa_sum, res_q[WIDTH-1:1]};

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign d         = d_q;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      sha_d     = sha_q;
      shb_d     = shb_q;
      res_d     = res_q;
      d_d       = d_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               sha_d   = a;
               shb_d   = ~b;
               carry_d = 1'b1;
               cnt_d   = '0;
               state_d = S_SUB;
            end
         end
         S_SUB, S_CORR: begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            res_d   = res_shift;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if ((state_q == S_SUB) && !fa_cout) begin
                  // Borrow: wrapped difference goes back through the adder with MODULUS
                  sha_d   = res_shift;
                  shb_d   = MOD_W;
                  carry_d = 1'b0;
                  state_d = S_CORR;
               end else begin
                  d_d     = res_shift;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_SUB) || (state_d == S_CORR);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sha_q       <= '0;
         shb_q       <= '0;
         res_q       <= '0;
         d_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sha_q       <= sha_d;
         shb_q       <= shb_d;
         res_q       <= res_d;
         d_q         <= d_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_serial_mod_sub.sv
// Directed and randomised checks for serial_mod_sub (WIDTH=12, MODULUS=3329).
module tb_serial_mod_sub;

   localparam int unsigned WIDTH   = 12;
   localparam int unsigned MODULUS = 3329;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             busy;

   int unsigned n_tests;
   int unsigned n_fail;

   serial_mod_sub #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Wait (bounded) for in_ready, then present one operand pair for one edge
   task automatic accept_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // After accept_op, count cycles to out_valid and busy cycles; check result
   task automatic wait_result(input string tag, input int exp_d, input int exp_lat,
                              input int exp_busy);
      int lat;
      int nbusy;
      lat   = 1;
      nbusy = 0;
      while (!out_valid && lat < 100) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_d"}, 32'(d), 32'(exp_d));
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_busy"}, 32'(nbusy), 32'(exp_busy));
   endtask

   // Let the held result go and confirm the block is back in IDLE
   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int unsigned ra, rb, exp;
      int n;
      logic [WIDTH-1:0] held;

      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_d", 32'(d), 32'd0);
      rst_n = 1'b1;

      // No borrow
      accept_op(12'd100, 12'd30);
      wait_result("nob", 70, 13, 12);
      release_result("nob");

      // Borrow with correction
      accept_op(12'd30, 12'd100);
      wait_result("bor", 3259, 25, 24);
      release_result("bor");

      // Boundary operands
      accept_op(12'd3328, 12'd3328);
      wait_result("eqmax", 0, 13, 12);
      release_result("eqmax");
      accept_op(12'd0, 12'd3328);
      wait_result("zmax", 1, 25, 24);
      release_result("zmax");

      // Backpressure: result held, new operands ignored
      out_ready = 1'b0;
      accept_op(12'd5, 12'd9);
      wait_result("bp", 3325, 25, 24);
      in_valid = 1'b1;
      a        = 12'd1;
      b        = 12'd2;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
         check_eq("bp_hold_d", 32'(d), 32'd3325);
         check_eq("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      release_result("bp");

      // Reset during CORR count 4
      accept_op(12'd30, 12'd100);
      repeat (16) @(negedge clk);
      check_eq("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_d", 32'(d), 32'd0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      accept_op(12'd7, 12'd7);
      wait_result("post_rst", 0, 13, 12);
      release_result("post_rst");

      // Random in-range pairs with random consumer stalls
      for (int k = 0; k < 200; k++) begin
         ra  = $urandom_range(MODULUS - 1, 0);
         rb  = $urandom_range(MODULUS - 1, 0);
         exp = (ra >= rb) ? (ra - rb) : (ra + MODULUS - rb);
         out_ready = 1'b0;
         accept_op(WIDTH'(ra), WIDTH'(rb));
         n = 0;
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         check_eq("rnd_valid", 32'(out_valid), 32'd1);
         held = d;
         n    = 0;
         out_ready = 1'($urandom_range(1, 0));
         while (!out_ready && n < 20) begin
            @(negedge clk);
            if (d !== held) check_eq("rnd_stable", 32'(d), 32'(held));
            out_ready = 1'($urandom_range(1, 0));
            n++;
         end
         out_ready = 1'b1;
         check_eq("rnd_d", 32'(d), exp);
         @(negedge clk);
         check_eq("rnd_nodup", 32'(out_valid), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
